mc_ctrl: RTL and testbench

Multi-cycle sequencer for the single-issue MIPS datapath. It sequences the instruction fetch unit (PC register, 1024-word instruction memory, instruction register), the GRF, the ALU and the DM through FETCH/DECODE/EXEC/MEM/WB states. It also drives every write enable and mux select from the latched opcode/func and the ALU zero flag. It sits beside the datapath; the fetch unit loads `npc` only when this block asserts `pc_we`.

---
 rtl/mc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Optional macro MC_CTRL_IMEM_WAIT_EN adds imem_ready to stall FETCH.
module mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
`ifdef MC_CTRL_IMEM_WAIT_EN
  input  logic        imem_ready,
`endif
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        grf_we,
  output logic [1:0]  a3_sel,
  output logic [1:0]  wd_sel,
  output logic [2:0]  alu_op,
  output logic        alu_b_sel,
  output logic        ext_op,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instr_count
);

  // The datapath owns the PC; a misaligned reset vector is a build error there too.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("mc_ctrl: RESET_PC must be word aligned");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_UNK
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  state_t      state_q, state_d;
  cls_t        cls;
  logic [31:0] count_q;
  logic        fetch_go;

`ifdef MC_CTRL_IMEM_WAIT_EN
  assign fetch_go = imem_ready;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    cls = C_UNK;
    case (opcode)
      6'h00: begin
        case (func)
          6'h21:   cls = C_ADDU;
          6'h23:   cls = C_SUBU;
          6'h08:   cls = C_JR;
          default: cls = C_UNK;
        endcase
      end
      6'h0d:   cls = C_ORI;
      6'h0f:   cls = C_LUI;
      6'h23:   cls = C_LW;
      6'h2b:   cls = C_SW;
      6'h04:   cls = C_BEQ;
      6'h03:   cls = C_JAL;
      default: cls = C_UNK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = 2'd0;
    grf_we    = 1'b0;
    a3_sel    = 2'd0;
    wd_sel    = 2'd0;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    dm_we     = 1'b0;
    if (!reset) begin
      // Selects depend only on the latched instruction so they stay stable across its states.
      alu_b_sel = (cls == C_ORI) || (cls == C_LUI) || (cls == C_LW) || (cls == C_SW);
      ext_op    = (cls == C_LW) || (cls == C_SW) || (cls == C_BEQ);
      case (cls)
        C_ORI:        alu_op = ALU_OR;
        C_LUI:        alu_op = ALU_LUI;
        C_SUBU, C_BEQ: alu_op = ALU_SUB;
        default:      alu_op = ALU_ADD;
      endcase
      if (cls == C_JAL) begin
        a3_sel = 2'd2;
        wd_sel = 2'd2;
      end else begin
        a3_sel = ((cls == C_ADDU) || (cls == C_SUBU)) ? 2'd1 : 2'd0;
        wd_sel = (cls == C_LW) ? 2'd1 : 2'd0;
      end

      case (state_q)
        S_FETCH: begin
          ir_we   = fetch_go;
          state_d = fetch_go ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          case (cls)
            C_JAL: begin
              grf_we  = 1'b1;
              pc_we   = 1'b1;
              npc_sel = 2'd2;
              state_d = S_FETCH;
            end
            C_JR: begin
              pc_we   = 1'b1;
              npc_sel = 2'd3;
              state_d = S_FETCH;
            end
            C_UNK: begin
              pc_we   = 1'b1;
              npc_sel = 2'd0;
              state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_LW, C_SW: state_d = S_MEM;
            C_BEQ: begin
              pc_we   = 1'b1;
              npc_sel = zero ? 2'd1 : 2'd0;
              state_d = S_FETCH;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          if (cls == C_SW) begin
            dm_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          grf_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (pc_we) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign retire      = pc_we;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with a per-instruction cycle model.
module tb_mc_ctrl;

  logic        clk, reset, zero;
  logic [5:0]  opcode, func;
  logic        ir_we, pc_we, grf_we, alu_b_sel, ext_op, dm_we, retire;
  logic [1:0]  npc_sel, a3_sel, wd_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_count;
`ifdef MC_CTRL_IMEM_WAIT_EN
  logic        imem_ready;
`endif

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
`ifdef MC_CTRL_IMEM_WAIT_EN
    .imem_ready(imem_ready),
`endif
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .grf_we(grf_we),
    .a3_sel(a3_sel), .wd_sel(wd_sel), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
    .ext_op(ext_op), .dm_we(dm_we), .state(state), .retire(retire),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_JAL = 8, K_UNK = 9;

  typedef struct {
    logic [2:0]  st;
    logic        ir, pc, grf, dm, sel;
    logic [1:0]  npc, a3, wd;
    logic [2:0]  aop;
    logic        bsel, ext;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mcount = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction semantics: which states it walks through and what it must do in each.
  task automatic push_instr(input int k, input logic z);
    int    path[$];
    exp_t  e;
    case (k)
      K_JAL, K_JR, K_UNK: path = '{0, 1};
      K_BEQ:              path = '{0, 1, 2};
      K_SW:               path = '{0, 1, 2, 3};
      K_LW:               path = '{0, 1, 2, 3, 4};
      default:            path = '{0, 1, 2, 4};
    endcase
    foreach (path[i]) begin
      e.st   = 3'(path[i]);
      e.ir   = (path[i] == 0);
      e.pc   = (i == path.size() - 1);
      e.grf  = (path[i] == 4) || (k == K_JAL && path[i] == 1);
      e.dm   = (k == K_SW && path[i] == 3);
      e.npc  = (k == K_JAL) ? 2'd2 : (k == K_JR) ? 2'd3 : (k == K_BEQ && z) ? 2'd1 : 2'd0;
      e.sel  = (path[i] != 0);
      e.a3   = (k == K_JAL) ? 2'd2 : (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
      e.wd   = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
      e.aop  = (k == K_ORI) ? 3'd2 : (k == K_LUI) ? 3'd3 : (k == K_SUBU || k == K_BEQ) ? 3'd1 : 3'd0;
      e.bsel = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
      e.ext  = (k == K_LW || k == K_SW || k == K_BEQ);
      e.cnt  = mcount;
      q.push_back(e);
    end
    mcount = mcount + 32'd1;
  endtask

  task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      K_JR:   begin op = 6'h00; fn = 6'h08; end
      K_ORI:  op = 6'h0d;
      K_LUI:  op = 6'h0f;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2b;
      K_BEQ:  op = 6'h04;
      K_JAL:  op = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          op = 6'h00;
          while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'($urandom);
        end else begin
          op = 6'($urandom_range(1, 63));
          while (op == 6'h0d || op == 6'h0f || op == 6'h23 || op == 6'h2b ||
                 op == 6'h04 || op == 6'h03) op = 6'($urandom_range(1, 63));
        end
      end
    endcase
  endtask

  // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 in the next FETCH.
  task automatic run_instr(input int k, input logic z);
    logic [5:0] op, fn;
    int n;
    encode(k, op, fn);
    n = q.size();
    push_instr(k, z);
    n = q.size() - n;
    @(posedge clk);
    #1;
    opcode = op;
    func   = fn;
    zero   = z;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("ir_we", 32'(ir_we), 32'(e.ir));
        chk("pc_we", 32'(pc_we), 32'(e.pc));
        chk("retire", 32'(retire), 32'(e.pc));
        chk("grf_we", 32'(grf_we), 32'(e.grf));
        chk("dm_we", 32'(dm_we), 32'(e.dm));
        chk("instr_count", instr_count, e.cnt);
        if (e.pc) chk("npc_sel", 32'(npc_sel), 32'(e.npc));
        if (e.sel) begin
          chk("alu_op", 32'(alu_op), 32'(e.aop));
          chk("alu_b_sel", 32'(alu_b_sel), 32'(e.bsel));
          chk("ext_op", 32'(ext_op), 32'(e.ext));
        end
        if (e.grf) begin
          chk("a3_sel", 32'(a3_sel), 32'(e.a3));
          chk("wd_sel", 32'(wd_sel), 32'(e.wd));
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    func   = 6'h00;
    zero   = 1'b0;
`ifdef MC_CTRL_IMEM_WAIT_EN
    imem_ready = 1'b1;
`endif
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_enables", {27'd0, ir_we, pc_we, grf_we, dm_we, retire}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_instr(K_ADDU, 1'b0);
    run_instr(K_LW, 1'b0);
    run_instr(K_SW, 1'b1);
    run_instr(K_BEQ, 1'b1);
    run_instr(K_BEQ, 1'b0);
    run_instr(K_JAL, 1'b1);
    run_instr(K_JR, 1'b0);
    run_instr(K_UNK, 1'b0);

`ifdef MC_CTRL_IMEM_WAIT_EN
    begin
      exp_t h;
      h = '{st: 3'd0, ir: 1'b0, pc: 1'b0, grf: 1'b0, dm: 1'b0, sel: 1'b0,
            npc: 2'd0, a3: 2'd0, wd: 2'd0, aop: 3'd0, bsel: 1'b0, ext: 1'b0, cnt: mcount};
      repeat (3) q.push_back(h);
      imem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      imem_ready = 1'b1;
      run_instr(K_ORI, 1'b0);
    end
`endif

    // Abandon an ori in EXEC: reset must take effect without a clock edge.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    opcode = 6'h0d;
    func   = 6'h00;
    @(posedge clk);
    #1;
    chk("ori_in_exec", 32'(state), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_grf_we", 32'(grf_we), 32'd0);
    chk("async_reset_pc_we", 32'(pc_we), 32'd0);
    mcount = 32'd0;
    chk("async_reset_count", instr_count, mcount);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Counter wrap: preload all-ones, then retire one instruction.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    mcount = 32'hFFFF_FFFF;
    run_instr(K_ADDU, 1'b0);
    run_instr(K_LUI, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_instr(int'($urandom_range(0, 9)), 1'($urandom));
    end

    mon_en = 1'b0;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
